// File: rtl/spi_sensor_if.sv
// Bundle for the SPI pins and the sample-push side of the sensor responder.
// The master modport drives the pins and samples; the slave modport is the responder.
interface spi_sensor_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                  sck;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  sample_valid;
  logic                  sample_ready;
  logic [LW-1:0]         fifo_level;
  logic                  xfer_done;
  logic                  overflow;
  logic                  underrun;

  modport master (
    output sck, cs_n, mosi, sample_data, sample_valid,
    input  miso, miso_oe, sample_ready, fifo_level, xfer_done, overflow, underrun
  );

  modport slave (
    input  sck, cs_n, mosi, sample_data, sample_valid,
    output miso, miso_oe, sample_ready, fifo_level, xfer_done, overflow, underrun
  );
endinterface

// File: rtl/spi_sensor_responder.sv
// Mode-0 SPI slave that serves locally produced samples from a FIFO.
// SPI pins are oversampled in the clk domain; command effects commit only on a full frame.
module spi_sensor_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  spi_sensor_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] CMD_READ_SAMPLE = 8'h01;
  localparam logic [7:0] CMD_READ_STATUS = 8'h02;

  // Synchronizers, reset to the idle bus state (sck low, cs_n high)
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, cs_s, mosi_s, sck_rise, sck_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // Sample FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic                  ready_q;
  logic                  push, pop;

  assign push    = bus.sample_valid & ready_q;
  assign level_d = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      ready_q <= (level_d != LW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.sample_data;
  end

  // Frame FSM
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            cmd_q, cmd_d, cmd_next;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, resp_w, status_w;
  logic                  had_q, had_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d, unr_q, unr_d;
  logic                  unr_set, stat_clr;

  assign cmd_next = {cmd_q[6:0], mosi_s};

  // Status: overflow in the MSB, underrun below it, occupancy in the LSBs
  always_comb begin
    status_w                 = '0;
    status_w[LW-1:0]         = level_q;
    status_w[DATA_WIDTH-1]   = ovf_q;
    status_w[DATA_WIDTH-2]   = unr_q;
    case (cmd_next)
      CMD_READ_SAMPLE: resp_w = (level_q != '0) ? mem_q[rptr_q] : '0;
      CMD_READ_STATUS: resp_w = status_w;
      default:         resp_w = '1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    shift_d  = shift_q;
    had_d    = had_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    unr_set  = 1'b0;
    stat_clr = 1'b0;
    if (cs_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
        S_CMD: begin
          if (sck_rise) begin
            cmd_d = cmd_next;
            if (cnt_q == CW'(7)) begin
              state_d = S_RESP;
              cnt_d   = '0;
              shift_d = resp_w;
              had_d   = (level_q != '0);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_RESP: begin
          if (sck_rise) begin
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              if (cmd_q == CMD_READ_SAMPLE) begin
                pop     = had_q;
                unr_set = ~had_q;
              end else if (cmd_q == CMD_READ_STATUS) begin
                stat_clr = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          // The fall right after the load must keep the MSB on the wire
          end else if (sck_fall && cnt_q != '0) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // A new event in the same cycle as a status-read clear wins
  always_comb begin
    ovf_d = ovf_q;
    unr_d = unr_q;
    if (stat_clr) begin
      ovf_d = 1'b0;
      unr_d = 1'b0;
    end
    if (bus.sample_valid && !ready_q) ovf_d = 1'b1;
    if (unr_set) unr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      shift_q <= '0;
      had_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      shift_q <= shift_d;
      had_q   <= had_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unr_q   <= unr_d;
    end
  end

  assign bus.miso_oe      = ~cs_s;
  assign bus.miso         = ~cs_s & (state_q == S_RESP || state_q == S_DONE) & shift_q[DATA_WIDTH-1];
  assign bus.sample_ready = ready_q;
  assign bus.fifo_level   = level_q;
  assign bus.xfer_done    = done_q;
  assign bus.overflow     = ovf_q;
  assign bus.underrun     = unr_q;
endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed bench for spi_sensor_responder: table of SPI frames plus hand-written corner sequences.
module tb_spi_sensor_responder;
  localparam int DW   = 16;
  localparam int D    = 8;
  localparam int HALF = 5;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   errs     = 0;
  int   done_cnt = 0;

  spi_sensor_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) bus ();

  spi_sensor_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.xfer_done === 1'b1) done_cnt++;

  typedef struct {
    logic [7:0]    cmd;
    int            nsck;
    logic [DW-1:0] rx;
    int            lvl;
    bit            ovf;
    bit            unr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    bus.sample_data  = d;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
  endtask

  // Mode-0 master: mosi set while sck low, miso sampled at each rising edge
  task automatic frame(input logic [7:0] cmd, input int nsck, input bit end_cs,
                       input bit push_en, input logic [DW-1:0] push_val,
                       output logic [DW-1:0] rx);
    rx = '0;
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nsck; i++) begin
      bus.mosi = (i < 8) ? cmd[7-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      bus.sck = 1'b1;
      if (i >= 8 && i < 8 + DW) rx = {rx[DW-2:0], bus.miso};
      if (push_en && i == 8 + DW - 1) begin
        repeat (2) @(negedge clk);
        bus.sample_data  = push_val;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus.sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (end_cs) begin
      bus.cs_n = 1'b1;
      repeat (2 * HALF) @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_miso"},    32'(bus.miso), 0);
    chk({tag, "_oe"},      32'(bus.miso_oe), 0);
    chk({tag, "_ready"},   32'(bus.sample_ready), 1);
    chk({tag, "_level"},   32'(bus.fifo_level), 0);
    chk({tag, "_done"},    32'(bus.xfer_done), 0);
    chk({tag, "_ovf"},     32'(bus.overflow), 0);
    chk({tag, "_unr"},     32'(bus.underrun), 0);
  endtask

  initial begin
    logic [DW-1:0] rx;
    int d0;

    vecs[0] = '{8'h01, 24, 16'hA5A5, 1, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 24, 16'h0001, 1, 1'b0, 1'b0};
    vecs[2] = '{8'h7F, 24, 16'hFFFF, 1, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 26, 16'h1234, 0, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 24, 16'h0000, 0, 1'b0, 1'b1};
    vecs[5] = '{8'h02, 24, 16'h4000, 0, 1'b0, 1'b0};
    vecs[6] = '{8'h02, 24, 16'h0000, 0, 1'b0, 1'b0};

    rst = 1'b1;
    bus.sck = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.sample_data = '0; bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    push(16'hA5A5);
    push(16'h1234);
    chk("level_after_push", 32'(bus.fifo_level), 2);

    for (int i = 0; i < 7; i++) begin
      d0 = done_cnt;
      frame(vecs[i].cmd, vecs[i].nsck, 1'b1, 1'b0, '0, rx);
      chk($sformatf("vec%0d_rx", i),    32'(rx), 32'(vecs[i].rx));
      chk($sformatf("vec%0d_level", i), 32'(bus.fifo_level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d_done", i),  32'(done_cnt - d0), 1);
      chk($sformatf("vec%0d_ovf", i),   32'(bus.overflow), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_unr", i),   32'(bus.underrun), 32'(vecs[i].unr));
    end

    // Abort after 10 sck: nothing commits, the same word is served next
    push(16'hBEEF);
    d0 = done_cnt;
    frame(8'h01, 10, 1'b1, 1'b0, '0, rx);
    chk("abort_done",  32'(done_cnt - d0), 0);
    chk("abort_level", 32'(bus.fifo_level), 1);
    d0 = done_cnt;
    frame(8'h01, 24, 1'b1, 1'b0, '0, rx);
    chk("abort_reread_rx",    32'(rx), 32'h0000BEEF);
    chk("abort_reread_done",  32'(done_cnt - d0), 1);
    chk("abort_reread_level", 32'(bus.fifo_level), 0);

    // Back-to-back burst of DEPTH+1 samples: the last one is dropped
    for (int i = 0; i < D + 1; i++) begin
      bus.sample_data  = 16'h1000 + 16'(i);
      bus.sample_valid = 1'b1;
      @(negedge clk);
    end
    bus.sample_valid = 1'b0;
    @(negedge clk);
    chk("ovf_ready", 32'(bus.sample_ready), 0);
    chk("ovf_flag",  32'(bus.overflow), 1);
    chk("ovf_level", 32'(bus.fifo_level), D);
    for (int i = 0; i < D; i++) begin
      frame(8'h01, 24, 1'b1, 1'b0, '0, rx);
      chk($sformatf("ovf_read%0d", i), 32'(rx), 32'h1000 + i);
    end
    chk("ovf_ready_after_drain", 32'(bus.sample_ready), 1);
    frame(8'h02, 24, 1'b1, 1'b0, '0, rx);
    chk("ovf_status_rx",  32'(rx), 32'h00008000);
    chk("ovf_cleared",    32'(bus.overflow), 0);

    // Push lands on the READ_SAMPLE commit cycle at level 3
    push(16'h3000);
    push(16'h3001);
    push(16'h3002);
    chk("sim_level_pre", 32'(bus.fifo_level), 3);
    frame(8'h01, 24, 1'b1, 1'b1, 16'h3003, rx);
    chk("sim_rx",    32'(rx), 32'h00003000);
    chk("sim_level", 32'(bus.fifo_level), 3);
    for (int i = 1; i < 4; i++) begin
      frame(8'h01, 24, 1'b1, 1'b0, '0, rx);
      chk($sformatf("sim_read%0d", i), 32'(rx), 32'h3000 + i);
    end
    chk("sim_level_end", 32'(bus.fifo_level), 0);

    // Asynchronous reset in the middle of a response
    push(16'hFFFF);
    push(16'h6666);
    frame(8'h01, 12, 1'b0, 1'b0, '0, rx);
    chk("mid_resp_miso", 32'(bus.miso), 1);
    #3 rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    frame(8'h02, 24, 1'b1, 1'b0, '0, rx);
    chk("post_rst_status", 32'(rx), 0);
    chk("post_rst_done",   32'(done_cnt - d0), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
